// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial 74181 ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_XOR = 4'b0110;
  localparam logic [3:0] SEL_AND = 4'b1011;

  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181-style slice, active-high data, active-low carry.
// ALU_NIBBLE_SEQ_FLAGS_EN adds c3, the carry into bit 3, for overflow.
module alu181_slice
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sel,
  input  logic       mode,
  input  logic       cn_n,
  output logic [3:0] f,
  output logic       cout_n,
  output logic       p_n,
  output logic       g_n,
  output logic       aeqb
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
  ,
  output logic       c3
`endif
);

  logic [3:0] t1;
  logic [3:0] t2;
  logic [4:0] c;

  // t2 implies t1 bitwise, so t1 acts as propagate and t2 as generate
  assign t1 = a | (b & {4{sel[0]}}) | (~b & {4{sel[1]}});
  assign t2 = (a & ~b & {4{sel[2]}}) | (a & b & {4{sel[3]}});

  always_comb begin
    c    = '0;
    c[0] = ~cn_n;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = t2[i] | (t1[i] & c[i]);
    end
  end

  assign f = (mode == MODE_LOGIC) ? ~(t1 ^ t2)
                                  : (t1 ^ t2 ^ c[3:0]);

  assign cout_n = ~c[4];
  assign p_n    = ~&t1;
  assign g_n    = ~(t2[3]
                  | (t1[3] & t2[2])
                  | (t1[3] & t1[2] & t2[1])
                  | (&t1[3:1] & t2[0]));
  assign aeqb   = &f;

`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
  assign c3 = c[3];
`endif

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial WIDTH-bit ALU: one shared 74181 slice, LSB nibble first.
// ALU_NIBBLE_SEQ_FLAGS_EN adds zero and signed-overflow outputs.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             mode,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             a_eq_b
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  seq_state_t       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       sel_r;
  logic             mode_r;
  logic             carry_r;
  logic             eq_r;

  logic [3:0] s_f;
  logic       s_cout_n;
  logic       s_aeqb;
  logic       s_unused_p_n;
  logic       s_unused_g_n;
  logic       carry_nx;
  logic       last;

`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
  logic s_c3;
  logic nz_r;
`endif

  alu181_slice u_slice (
    .a      (a_r[4*idx +: 4]),
    .b      (b_r[4*idx +: 4]),
    .sel    (sel_r),
    .mode   (mode_r),
    .cn_n   (~carry_r),
    .f      (s_f),
    .cout_n (s_cout_n),
    .p_n    (s_unused_p_n),
    .g_n    (s_unused_g_n),
    .aeqb   (s_aeqb)
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
    ,
    .c3     (s_c3)
`endif
  );

  assign carry_nx = (mode_r == MODE_LOGIC) ? 1'b0 : ~s_cout_n;
  assign last     = (idx == IW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sel_r   <= '0;
      mode_r  <= MODE_ARITH;
      carry_r <= 1'b0;
      eq_r    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      a_eq_b  <= 1'b0;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
      nz_r    <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sel_r   <= sel;
            mode_r  <= mode;
            carry_r <= cin & (mode != MODE_LOGIC);
            eq_r    <= 1'b1;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
            nz_r    <= 1'b0;
`endif
          end
        end
        RUN: begin
          result[4*idx +: 4] <= s_f;
          carry_r <= carry_nx;
          eq_r    <= eq_r & s_aeqb;
          idx     <= idx + IW'(1);
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
          nz_r    <= nz_r | (|s_f);
`endif
          if (last) begin
            cout   <= carry_nx;
            a_eq_b <= eq_r & s_aeqb;
            done   <= 1'b1;
            state  <= DONE;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
            zero   <= ~(nz_r | (|s_f));
            ovf    <= (mode_r == MODE_LOGIC) ? 1'b0
                                             : (s_c3 ^ ~s_cout_n);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed self-checking bench for alu_nibble_sequencer (WIDTH=16).
// Flag checks are compiled in with ALU_NIBBLE_SEQ_FLAGS_EN.
module tb_alu_nibble_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  sel;
  logic        mode;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        a_eq_b;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
  logic        zero;
  logic        ovf;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;
  int lat;
  int bcnt;
  int dcnt;

  alu_nibble_sequencer #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .mode   (mode),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .a_eq_b (a_eq_b)
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
    ,
    .zero   (zero),
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done.
  task automatic run_op(input logic [15:0] av,
                        input logic [15:0] bv,
                        input logic [3:0]  sv,
                        input logic        mv,
                        input logic        cv,
                        output int         l,
                        output int         bc);
    @(negedge clk);
    a = av; b = bv; sel = sv; mode = mv; cin = cv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l  = 1;
    bc = 0;
    while (!done && l < 40) begin
      if (busy) bc++;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; sel = '0; mode = 1'b0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_aeqb", 32'(a_eq_b), 32'h0);
    rst_n = 1'b1;

    run_op(16'h00FF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, lat, bcnt);
    check("add1_lat", 32'(lat), 32'd5);
    check("add1_busy_cycles", 32'(bcnt), 32'd4);
    check("add1_busy_at_done", 32'(busy), 32'h1);
    check("add1_result", 32'(result), 32'h0100);
    check("add1_cout", 32'(cout), 32'h0);

    run_op(16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, lat, bcnt);
    check("add2_lat", 32'(lat), 32'd5);
    check("add2_result", 32'(result), 32'h0000);
    check("add2_cout", 32'(cout), 32'h1);
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
    check("add2_zero", 32'(zero), 32'h1);
    check("add2_ovf", 32'(ovf), 32'h0);
`endif
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'h0);
    check("busy_after_done", 32'(busy), 32'h0);

    run_op(16'h1234, 16'h1234, SEL_SUB, MODE_ARITH, 1'b0, lat, bcnt);
    check("sub0_result", 32'(result), 32'hFFFF);
    check("sub0_aeqb", 32'(a_eq_b), 32'h1);
    check("sub0_cout", 32'(cout), 32'h0);

    run_op(16'h1234, 16'h1234, SEL_SUB, MODE_ARITH, 1'b1, lat, bcnt);
    check("sub1_result", 32'(result), 32'h0000);
    check("sub1_cout", 32'(cout), 32'h1);

    run_op(16'h1235, 16'h1234, SEL_SUB, MODE_ARITH, 1'b0, lat, bcnt);
    check("sub_ne_result", 32'(result), 32'h0000);
    check("sub_ne_aeqb", 32'(a_eq_b), 32'h0);
    check("sub_ne_cout", 32'(cout), 32'h1);

    run_op(16'h0005, 16'h0003, SEL_SUB, MODE_ARITH, 1'b1, lat, bcnt);
    check("sub2_result", 32'(result), 32'h0002);
    check("sub2_cout", 32'(cout), 32'h1);

    run_op(16'hF0F0, 16'h3C3C, SEL_AND, MODE_LOGIC, 1'b1, lat, bcnt);
    check("and_result", 32'(result), 32'h3030);
    check("and_cout", 32'(cout), 32'h0);

    // XOR with start held high while busy: must be ignored
    @(negedge clk);
    a = 16'hA5A5; b = 16'h0FF0; sel = SEL_XOR;
    mode = MODE_LOGIC; cin = 1'b0;
    start = 1'b1;
    dcnt = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("xor_done_count", 32'(dcnt), 32'd1);
    check("xor_result", 32'(result), 32'hAA55);
    check("xor_cout", 32'(cout), 32'h0);

    // Reset during the second RUN cycle aborts the operation
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sel = SEL_ADD;
    mode = MODE_ARITH; cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_cout", 32'(cout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);

    run_op(16'h7FFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, lat, bcnt);
    check("post_abort_lat", 32'(lat), 32'd5);
    check("ovf_result", 32'(result), 32'h8000);
    check("ovf_cout", 32'(cout), 32'h0);
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
    check("ovf_ovf", 32'(ovf), 32'h1);
    check("ovf_zero", 32'(zero), 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
